// File: rtl/ie_requisitor_if.sv
// ----------------------------------------------------------------------------
// ie_requisitor_if
// Station-to-arbiter request channel.
//
// Handshake: the requisitor raises req together with a stable req_fun and
// req_perf and holds all three until the arbiter answers. The arbiter accepts
// by raising ack for a cycle while req is high; req drops on the following
// edge. If no ack arrives within the hold window, the requisitor withdraws req
// by itself. ack seen while req is low has no effect.
//
// Signals:
//   req       requisitor -> arbiter  request valid
//   req_fun   requisitor -> arbiter  function code {mode, btn1, btn0}
//   req_perf  requisitor -> arbiter  profile code (01, 10, 11)
//   ack       arbiter -> requisitor  current request accepted
// ----------------------------------------------------------------------------
interface ie_requisitor_if;
  logic       req;
  logic [2:0] req_fun;
  logic [1:0] req_perf;
  logic       ack;

  modport master (output req, output req_fun, output req_perf, input ack);
  modport slave  (input req, input req_fun, input req_perf, output ack);
endinterface

// File: rtl/ie_requisitor.sv
// ----------------------------------------------------------------------------
// ie_requisitor
// Input-station request front end: synchronizes the station switches and
// buttons, debounces the buttons, and issues exactly one request per press
// toward the arbiter over ie_requisitor_if.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   ch_perfil  profile switches (one-hot expected), asynchronous
//   ch_modo    mode switch, asynchronous
//   btn        raw bouncy buttons, active-high
//   arb        request channel (master side): req, req_fun, req_perf, ack
//   busy       high whenever the FSM is not in IDLE
//   timeout    one-cycle pulse when a request is withdrawn unanswered
//   err_perfil one-cycle pulse when a press is rejected for a bad profile
//   dbg_state  current FSM state (00 IDLE, 01 REQ, 10 WAIT_REL)
// ----------------------------------------------------------------------------
module ie_requisitor #(
  parameter int DEB_CYCLES = 4,
  parameter int HOLD_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            ch_perfil,
  input  logic                  ch_modo,
  input  logic [1:0]            btn,
  ie_requisitor_if.master       arb,
  output logic                  busy,
  output logic                  timeout,
  output logic                  err_perfil,
  output logic [1:0]            dbg_state
);

  // Debounce flips on the edge where the count would reach DEB_CYCLES.
  localparam logic [3:0]  DEB_LAST  = 4'(DEB_CYCLES - 1);
  // Last cycle of the hold window; the withdrawal happens on its closing edge.
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_REL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       btn_s1_q, btn_s2_q;
  logic             modo_s1_q, modo_s2_q;
  logic [2:0]       perf_s1_q, perf_s2_q;
  logic [1:0]       db_q;
  logic [1:0][3:0]  cnt_q;
  logic [15:0]      hold_q, hold_d;
  logic [2:0]       fun_q, fun_d;
  logic [1:0]       perf_q, perf_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic [1:0]       perf_code;
  logic             perf_valid;

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      modo_s1_q <= 1'b0;
      modo_s2_q <= 1'b0;
      perf_s1_q <= '0;
      perf_s2_q <= '0;
    end else begin
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      modo_s1_q <= ch_modo;
      modo_s2_q <= modo_s1_q;
      perf_s1_q <= ch_perfil;
      perf_s2_q <= perf_s1_q;
    end
  end

  // Per-bit debounce: any single cycle of agreement restarts the count, so
  // only a disagreement lasting DEB_CYCLES consecutive edges flips db.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DEB_LAST) begin
            db_q[i]  <= btn_s2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-hot profile switches to a 2-bit code; anything else is rejected.
  always_comb begin
    perf_code  = 2'b00;
    perf_valid = 1'b0;
    case (perf_s2_q)
      3'b100: begin perf_code = 2'b11; perf_valid = 1'b1; end
      3'b010: begin perf_code = 2'b10; perf_valid = 1'b1; end
      3'b001: begin perf_code = 2'b01; perf_valid = 1'b1; end
      default: begin perf_code = 2'b00; perf_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      fun_q     <= '0;
      perf_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      fun_q     <= fun_d;
      perf_q    <= perf_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // IDLE is only re-entered once db is back at 00, so a non-zero db seen in
  // IDLE is always a fresh press. Buttons whose db flips later than the
  // capture edge are not merged into the latched code.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    fun_d     = fun_q;
    perf_d    = perf_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (db_q != 2'b00) begin
          if (perf_valid) begin
            fun_d   = {modo_s2_q, db_q};
            perf_d  = perf_code;
            hold_d  = '0;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_REL;
          end
        end
      end
      S_REQ: begin
        // ack takes priority over an expiring hold window.
        if (arb.ack) begin
          state_d = S_WAIT_REL;
        end else if (hold_q == HOLD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_WAIT_REL;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      S_WAIT_REL: begin
        if (db_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign arb.req      = (state_q == S_REQ);
  assign arb.req_fun  = fun_q;
  assign arb.req_perf = perf_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout      = timeout_q;
  assign err_perfil   = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ie_requisitor.sv
module tb_ie_requisitor;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ch_perfil;
  logic       ch_modo;
  logic [1:0] btn;
  logic       busy, timeout, err_perfil;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_count = 0;
  logic prev_req = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;

  ie_requisitor_if arb_if();

  ie_requisitor #(.DEB_CYCLES(DEB), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .ch_perfil(ch_perfil), .ch_modo(ch_modo),
    .btn(btn), .arb(arb_if), .busy(busy), .timeout(timeout),
    .err_perfil(err_perfil), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 30000) begin
      $display("FAIL watchdog cycles=%0d required<=30000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // scoreboard: every rising req must match the next expected {fun, perf}
  always @(negedge clk) begin
    if (arb_if.req === 1'b1 && prev_req !== 1'b1) begin
      rise_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req fun=%b perf=%b required=no request", arb_if.req_fun, arb_if.req_perf);
      end else begin
        exp_v = exp_q.pop_front();
        if ({arb_if.req_fun, arb_if.req_perf} !== exp_v) begin
          errors++;
          $display("FAIL req_code got=%b required=%b", {arb_if.req_fun, arb_if.req_perf}, exp_v);
        end
      end
    end
    prev_req = arb_if.req;
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [2:0] p, input logic m);
    ch_perfil = p;
    ch_modo   = m;
    cycles(3);
  endtask

  task automatic wait_req(input int start, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (arb_if.req === 1'b1) begin
        lat = cyc - start;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int waited);
    waited = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        waited = n;
        break;
      end
    end
  endtask

  task automatic do_ack();
    arb_if.ack = 1'b1;
    @(posedge clk);
    #1;
    arb_if.ack = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; btn = 2'b00; ch_modo = 1'b0; ch_perfil = 3'b000; arb_if.ack = 1'b0;
    cycles(3);
    @(negedge clk);
    checks++;
    if ({arb_if.req, busy, timeout, err_perfil} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b required=0000", {arb_if.req, busy, timeout, err_perfil});
    end
    checks++;
    if ({arb_if.req_fun, arb_if.req_perf} !== 5'b00000) begin
      errors++; $display("FAIL reset_codes got=%b required=00000", {arb_if.req_fun, arb_if.req_perf});
    end
    checks++;
    if (dbg_state !== 2'b00) begin
      errors++; $display("FAIL reset_state got=%b required=00", dbg_state);
    end
    cycles(1);
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_clean_press();
    int k, lat, w;
    set_sw(3'b100, 1'b1);
    exp_q.push_back({3'b101, 2'b11});
    btn = 2'b01; k = cyc;
    wait_req(k, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL clean_latency got=%0d required=%0d", lat, LAT); end
    do_ack();
    @(negedge clk);
    checks++;
    if ({arb_if.req, busy} !== 2'b01) begin
      errors++; $display("FAIL ack_drop req_busy=%b required=01", {arb_if.req, busy});
    end
    cycles(10);
    btn = 2'b00;
    cycles(5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL release_debouncing busy=%b required=1", busy); end
    cycles(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL release_idle busy=%b required=0", busy); end
    w = 0;
  endtask

  task automatic test_bounce();
    int k, lat, w, rc0;
    logic seen;
    set_sw(3'b100, 1'b0);
    exp_q.push_back({3'b001, 2'b11});
    btn = 2'b01; cycles(1);
    btn = 2'b00; cycles(1);
    btn = 2'b01; cycles(1);
    btn = 2'b00; cycles(1);
    btn = 2'b01; k = cyc;
    wait_req(k, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL bounce_latency got=%0d required=%0d", lat, LAT); end
    do_ack();
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL bounce_idle busy=%b required=0", busy); end
    // 3-cycle glitch must never reach db
    cycles(2);
    rc0 = rise_count; seen = 1'b0;
    btn = 2'b01; cycles(3); btn = 2'b00;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || rise_count != rc0) begin
      errors++; $display("FAIL glitch busy_seen=%b rises=%0d required busy_seen=0 rises=%0d", seen, rise_count, rc0);
    end
  endtask

  task automatic test_both_buttons();
    int k, lat, w, rc0;
    set_sw(3'b010, 1'b0);
    exp_q.push_back({3'b011, 2'b10});
    btn = 2'b11; k = cyc;
    wait_req(k, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL both_latency got=%0d required=%0d", lat, LAT); end
    do_ack();
    rc0 = rise_count;
    cycles(1000);
    checks++;
    if (rise_count != rc0 || busy !== 1'b1) begin
      errors++; $display("FAIL held_no_repeat rises=%0d busy=%b required rises=%0d busy=1", rise_count, busy, rc0);
    end
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL both_idle busy=%b required=0", busy); end
  endtask

  task automatic test_second_button();
    int k, lat, w;
    set_sw(3'b001, 1'b0);
    exp_q.push_back({3'b001, 2'b01});
    btn = 2'b01; k = cyc;
    cycles(2);
    btn = 2'b11;
    wait_req(k, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL second_latency got=%0d required=%0d", lat, LAT); end
    do_ack();
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL second_idle busy=%b required=0", busy); end
  endtask

  task automatic test_timeout();
    int k, lat, w, n;
    set_sw(3'b100, 1'b1);
    exp_q.push_back({3'b101, 2'b11});
    btn = 2'b01; k = cyc;
    wait_req(k, lat);
    n = 0;
    while (arb_if.req === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != HOLD) begin errors++; $display("FAIL hold_length got=%0d required=%0d", n, HOLD); end
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got=%b required=1", timeout); end
    @(negedge clk);
    checks++;
    if ({timeout, busy} !== 2'b01) begin
      errors++; $display("FAIL timeout_one_cycle timeout_busy=%b required=01", {timeout, busy});
    end
    btn = 2'b00;
    wait_idle(w);
    // ack on the last cycle of the window beats the timeout
    exp_q.push_back({3'b101, 2'b11});
    btn = 2'b01; k = cyc;
    wait_req(k, lat);
    repeat (HOLD - 1) @(negedge clk);
    checks++;
    if (arb_if.req !== 1'b1) begin errors++; $display("FAIL hold_last_cycle req=%b required=1", arb_if.req); end
    do_ack();
    @(negedge clk);
    checks++;
    if ({arb_if.req, timeout} !== 2'b00) begin
      errors++; $display("FAIL ack_beats_timeout req_timeout=%b required=00", {arb_if.req, timeout});
    end
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL timeout_idle busy=%b required=0", busy); end
  endtask

  task automatic test_bad_profile();
    int k, lat, w, rc0;
    set_sw(3'b110, 1'b1);
    rc0 = rise_count;
    btn = 2'b01; k = cyc;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (err_perfil === 1'b1) begin lat = cyc - k; break; end
    end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL err_latency got=%0d required=%0d", lat, LAT); end
    @(negedge clk);
    checks++;
    if ({err_perfil, busy, arb_if.req} !== 3'b010) begin
      errors++; $display("FAIL err_one_cycle err_busy_req=%b required=010", {err_perfil, busy, arb_if.req});
    end
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0 || dbg_state !== 2'b00 || rise_count != rc0) begin
      errors++; $display("FAIL err_to_idle waited=%0d state=%b rises=%0d required state=00 rises=%0d", w, dbg_state, rise_count, rc0);
    end
    // profile switch moved during REQ must not alter the latched code
    set_sw(3'b100, 1'b1);
    exp_q.push_back({3'b101, 2'b11});
    btn = 2'b01; k = cyc;
    wait_req(k, lat);
    ch_perfil = 3'b001;
    repeat (5) @(negedge clk);
    checks++;
    if ({arb_if.req, arb_if.req_perf} !== 3'b111) begin
      errors++; $display("FAIL perf_frozen req_perf=%b required=111", {arb_if.req, arb_if.req_perf});
    end
    do_ack();
    btn = 2'b00;
    wait_idle(w);
  endtask

  task automatic test_reset_mid();
    int k, lat, w;
    set_sw(3'b010, 1'b1);
    exp_q.push_back({3'b110, 2'b10});
    btn = 2'b10; k = cyc;
    wait_req(k, lat);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({arb_if.req, busy, timeout, err_perfil, arb_if.req_fun, arb_if.req_perf} !== 9'b0) begin
      errors++; $display("FAIL reset_mid got=%b required=000000000",
                         {arb_if.req, busy, timeout, err_perfil, arb_if.req_fun, arb_if.req_perf});
    end
    cycles(1);
    rst = 1'b0; k = cyc;
    exp_q.push_back({3'b110, 2'b10});
    wait_req(k, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL post_reset_latency got=%0d required=%0d", lat, LAT); end
    do_ack();
    btn = 2'b00;
    wait_idle(w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL post_reset_idle busy=%b required=0", busy); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_both_buttons();
    test_second_button();
    test_timeout();
    test_bad_profile();
    test_reset_mid();
    cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_expected left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
